// File: rtl/grouped_mac_array.sv
// -----------------------------------------------------------------------------
// grouped_mac_array
// Consumer end of the convolution-to-MAC interface. Each beat carries MAX_MACS
// packed int8 data/weight lanes that are split into up to MAX_GROUPS
// contiguous lane groups; one signed dot product is formed per group, and
// products can be accumulated (with saturation) over several beats before
// the result is emitted toward the requant/SRAM write path.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   mac_valid_i    beat valid (single-cycle pulse, no backpressure)
//   data_mac_i     packed signed data lanes, lane k at [8k+:8]
//   weight_mac_i   packed signed weight lanes
//   num_groups_i   active group count (values above MAX_GROUPS clamp)
//   num_macs_i     per-group lane count, group g at [6g+:6], 0 means 64
//   acc_first_i    beat starts a new accumulation
//   acc_last_i     beat ends the accumulation; result is emitted
//   input_offset_i signed 9-bit data offset (GROUPED_MAC_INPUT_OFFSET_EN only)
//   mac_valid_o    result valid pulse, 3 cycles after the acc_last beat
//   mac_out_o      group g result at [32g+:32], held until the next result
//   sat_flag_o     group g saturated during the emitted accumulation
//   busy_o         a beat is in the pipeline or an accumulation is open
//
// Optional feature macro: GROUPED_MAC_INPUT_OFFSET_EN
//   Adds input_offset_i; data lanes become data + offset (9-bit) before the
//   multiply, widening products to 17 bits (TFLite zero-point convention).
// -----------------------------------------------------------------------------
module grouped_mac_array #(
   parameter int MAX_MACS          = 64,
   parameter int DATA_WIDTH        = 8,
   parameter int QUANT_WIDTH       = 32,
   parameter int MAX_GROUPS        = 8,
   parameter int MAC_BIT_PER_GROUP = 6
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      mac_valid_i,
   input  logic [DATA_WIDTH*MAX_MACS-1:0]            data_mac_i,
   input  logic [DATA_WIDTH*MAX_MACS-1:0]            weight_mac_i,
   input  logic [$clog2(MAX_GROUPS+1)-1:0]           num_groups_i,
   input  logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0]   num_macs_i,
   input  logic                                      acc_first_i,
   input  logic                                      acc_last_i,
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
   input  logic signed [8:0]                         input_offset_i,
`endif
   output logic                                      mac_valid_o,
   output logic signed [MAX_GROUPS*QUANT_WIDTH-1:0]  mac_out_o,
   output logic [MAX_GROUPS-1:0]                     sat_flag_o,
   output logic                                      busy_o
);

   localparam int GRP_W  = $clog2(MAX_GROUPS+1);
   localparam int CNT_W  = $clog2(MAX_GROUPS*MAX_MACS+1);
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
   localparam int OPA_W  = DATA_WIDTH + 1;
`else
   localparam int OPA_W  = DATA_WIDTH;
`endif
   localparam int PROD_W = OPA_W + DATA_WIDTH;

   function automatic logic signed [QUANT_WIDTH-1:0] sat_q(input logic signed [QUANT_WIDTH:0] x);
      if (x[QUANT_WIDTH] != x[QUANT_WIDTH-1])
         sat_q = x[QUANT_WIDTH] ? {1'b1, {(QUANT_WIDTH-1){1'b0}}} : {1'b0, {(QUANT_WIDTH-1){1'b1}}};
      else
         sat_q = x[QUANT_WIDTH-1:0];
   endfunction

   function automatic logic sat_hit(input logic signed [QUANT_WIDTH:0] x);
      sat_hit = x[QUANT_WIDTH] ^ x[QUANT_WIDTH-1];
   endfunction

   // Group decode: prefix-sum of effective lane counts gives each group's
   // lane window; lanes past MAX_MACS simply never match.
   logic [GRP_W-1:0]    ng_eff;
   logic [CNT_W-1:0]    base_c;
   logic [CNT_W-1:0]    cnt_c;
   logic [MAX_MACS-1:0] own_c [MAX_GROUPS];

   always_comb begin
      ng_eff = (num_groups_i > GRP_W'(MAX_GROUPS)) ? GRP_W'(MAX_GROUPS) : num_groups_i;
      base_c = '0;
      cnt_c  = '0;
      for (int g = 0; g < MAX_GROUPS; g++) begin
         own_c[g] = '0;
         cnt_c    = '0;
         if (GRP_W'(g) < ng_eff) begin
            if (num_macs_i[g*MAC_BIT_PER_GROUP +: MAC_BIT_PER_GROUP] == '0)
               cnt_c = CNT_W'(MAX_MACS);
            else
               cnt_c = CNT_W'(num_macs_i[g*MAC_BIT_PER_GROUP +: MAC_BIT_PER_GROUP]);
         end
         for (int k = 0; k < MAX_MACS; k++)
            if (CNT_W'(k) >= base_c && CNT_W'(k) < base_c + cnt_c)
               own_c[g][k] = 1'b1;
         base_c = base_c + cnt_c;
      end
   end

   // ---- stage 0: registered beat and lane ownership ----
   logic                          vld_p0, first_p0, last_p0, acc_open;
   logic [DATA_WIDTH*MAX_MACS-1:0] data_p0, weight_p0;
   logic [MAX_MACS-1:0]           own_p0 [MAX_GROUPS];
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
   logic signed [8:0]             offset_p0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0   <= 1'b0;
         first_p0 <= 1'b0;
         last_p0  <= 1'b0;
         acc_open <= 1'b0;
      end else begin
         vld_p0   <= mac_valid_i;
         first_p0 <= mac_valid_i & acc_first_i;
         last_p0  <= mac_valid_i & acc_last_i;
         if (mac_valid_i) begin
            if (acc_last_i)
               acc_open <= 1'b0;
            else if (acc_first_i)
               acc_open <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mac_valid_i) begin
         data_p0   <= data_mac_i;
         weight_p0 <= weight_mac_i;
         own_p0    <= own_c;
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
         offset_p0 <= input_offset_i;
`endif
      end
   end

   // ---- stage 1: masked signed lane products ----
   logic signed [OPA_W-1:0]      opa_c;
   logic signed [DATA_WIDTH-1:0] opb_c;
   logic                         lane_en_c;
   logic signed [PROD_W-1:0]     prod_c [MAX_MACS];

   always_comb begin
      opa_c     = '0;
      opb_c     = '0;
      lane_en_c = 1'b0;
      for (int k = 0; k < MAX_MACS; k++) begin
         lane_en_c = 1'b0;
         for (int g = 0; g < MAX_GROUPS; g++)
            lane_en_c = lane_en_c | own_p0[g][k];
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
         opa_c = $signed({data_p0[k*DATA_WIDTH+DATA_WIDTH-1], data_p0[k*DATA_WIDTH +: DATA_WIDTH]})
                 + offset_p0;
`else
         opa_c = $signed(data_p0[k*DATA_WIDTH +: DATA_WIDTH]);
`endif
         opb_c = $signed(weight_p0[k*DATA_WIDTH +: DATA_WIDTH]);
         if (lane_en_c)
            prod_c[k] = PROD_W'(opa_c) * PROD_W'(opb_c);
         else
            prod_c[k] = '0;
      end
   end

   logic                     vld_p1, first_p1, last_p1;
   logic signed [PROD_W-1:0] prod_p1 [MAX_MACS];
   logic [MAX_MACS-1:0]      own_p1  [MAX_GROUPS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1   <= 1'b0;
         first_p1 <= 1'b0;
         last_p1  <= 1'b0;
      end else begin
         vld_p1   <= vld_p0;
         first_p1 <= first_p0;
         last_p1  <= last_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (vld_p0) begin
         prod_p1 <= prod_c;
         own_p1  <= own_p0;
      end
   end

   // ---- stage 2/3: per-group sum feeding the saturating accumulator ----
   // The group sum cannot overflow QUANT_WIDTH, so only the accumulate step
   // needs a guard bit.
   logic signed [QUANT_WIDTH-1:0] sum_c  [MAX_GROUPS];
   logic signed [QUANT_WIDTH-1:0] acc_q  [MAX_GROUPS];
   logic signed [QUANT_WIDTH-1:0] acc_nx [MAX_GROUPS];
   logic signed [QUANT_WIDTH:0]   wide_c;
   logic [MAX_GROUPS-1:0]         sat_acc, sat_nx;

   always_comb begin
      wide_c = '0;
      sat_nx = '0;
      for (int g = 0; g < MAX_GROUPS; g++) begin
         sum_c[g] = '0;
         for (int k = 0; k < MAX_MACS; k++)
            if (own_p1[g][k])
               sum_c[g] = sum_c[g]
                          + $signed({{(QUANT_WIDTH-PROD_W){prod_p1[k][PROD_W-1]}}, prod_p1[k]});
         wide_c = $signed({acc_q[g][QUANT_WIDTH-1], acc_q[g]})
                  + $signed({sum_c[g][QUANT_WIDTH-1], sum_c[g]});
         if (first_p1) begin
            acc_nx[g] = sum_c[g];
            sat_nx[g] = 1'b0;
         end else begin
            acc_nx[g] = sat_q(wide_c);
            sat_nx[g] = sat_acc[g] | sat_hit(wide_c);
         end
      end
   end

   // The accumulator is cleared when a result is emitted so that a following
   // beat without acc_first starts from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int g = 0; g < MAX_GROUPS; g++)
            acc_q[g] <= '0;
         sat_acc     <= '0;
         mac_out_o   <= '0;
         sat_flag_o  <= '0;
         mac_valid_o <= 1'b0;
      end else begin
         mac_valid_o <= vld_p1 & last_p1;
         if (vld_p1) begin
            if (last_p1) begin
               for (int g = 0; g < MAX_GROUPS; g++) begin
                  mac_out_o[g*QUANT_WIDTH +: QUANT_WIDTH] <= acc_nx[g];
                  acc_q[g] <= '0;
               end
               sat_flag_o <= sat_nx;
               sat_acc    <= '0;
            end else begin
               for (int g = 0; g < MAX_GROUPS; g++)
                  acc_q[g] <= acc_nx[g];
               sat_acc <= sat_nx;
            end
         end
      end
   end

   assign busy_o = vld_p0 | vld_p1 | acc_open;

endmodule

// File: tb/tb_grouped_mac_array.sv
module tb_grouped_mac_array;

   localparam int NM = 64;
   localparam int DW = 8;
   localparam int QW = 32;
   localparam int NG = 8;
   localparam int MB = 6;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic                 clk;
   logic                 rst;
   logic                 mac_valid_i;
   logic [DW*NM-1:0]     data_mac_i;
   logic [DW*NM-1:0]     weight_mac_i;
   logic [3:0]           num_groups_i;
   logic [NG*MB-1:0]     num_macs_i;
   logic                 acc_first_i;
   logic                 acc_last_i;
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
   logic signed [8:0]    input_offset_i;
`endif
   logic                 mac_valid_o;
   logic signed [NG*QW-1:0] mac_out_o;
   logic [NG-1:0]        sat_flag_o;
   logic                 busy_o;

   grouped_mac_array dut (
      .clk          (clk),
      .rst          (rst),
      .mac_valid_i  (mac_valid_i),
      .data_mac_i   (data_mac_i),
      .weight_mac_i (weight_mac_i),
      .num_groups_i (num_groups_i),
      .num_macs_i   (num_macs_i),
      .acc_first_i  (acc_first_i),
      .acc_last_i   (acc_last_i),
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
      .input_offset_i (input_offset_i),
`endif
      .mac_valid_o  (mac_valid_o),
      .mac_out_o    (mac_out_o),
      .sat_flag_o   (sat_flag_o),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NG*QW-1:0] out;
      logic [NG-1:0]    sat;
      int               cyc;
      int               tag;
   } exp_t;

   exp_t   sb_q[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   int     cyc = 0;
   int     n_pulses = 0;
   longint m_acc [NG];
   logic [NG-1:0] m_sat;

   always @(posedge clk) cyc++;

   // Scoreboard consumer: every result pulse is matched against the oldest
   // expectation, including its arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst && mac_valid_o) begin
         n_pulses++;
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result got out=%h sat=%b cyc=%0d, none expected",
                     mac_out_o, sat_flag_o, cyc);
         end else begin
            e = sb_q.pop_front();
            if (mac_out_o !== e.out || sat_flag_o !== e.sat || cyc !== e.cyc) begin
               n_fail++;
               $display("FAIL result tag=%0d got out=%h sat=%b cyc=%0d want out=%h sat=%b cyc=%0d",
                        e.tag, mac_out_o, sat_flag_o, cyc, e.out, e.sat, e.cyc);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         mac_valid_i = 1'b0;
         acc_first_i = 1'b0;
         acc_last_i  = 1'b0;
      end
   endtask

   // Drives one beat and advances the reference model; pushes an expectation
   // when the beat closes an accumulation.
   task automatic beat(input logic [DW*NM-1:0] d, input logic [DW*NM-1:0] w, input int ng,
                       input logic [NG*MB-1:0] nm, input logic first, input logic last,
                       input int off, input int tag);
      longint s [NG];
      longint t;
      int lane, ngc, n, a, wi;
      logic signed [7:0] dv, wv;
      exp_t e;
      @(negedge clk);
      mac_valid_i  = 1'b1;
      data_mac_i   = d;
      weight_mac_i = w;
      num_groups_i = ng[3:0];
      num_macs_i   = nm;
      acc_first_i  = first;
      acc_last_i   = last;
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
      input_offset_i = off[8:0];
`endif
      ngc  = (ng > NG) ? NG : ng;
      lane = 0;
      for (int g = 0; g < NG; g++) s[g] = 0;
      for (int g = 0; g < ngc; g++) begin
         n = int'(nm[g*MB +: MB]);
         if (n == 0) n = NM;
         for (int j = 0; j < n; j++) begin
            if (lane < NM) begin
               dv = d[lane*DW +: DW];
               wv = w[lane*DW +: DW];
               a  = dv;
               a  = a + off;
               a  = ((a + 256) % 512 + 512) % 512 - 256;
               wi = wv;
               s[g] = s[g] + longint'(a * wi);
            end
            lane++;
         end
      end
      for (int g = 0; g < NG; g++) begin
         if (first) begin
            m_acc[g] = s[g];
            m_sat[g] = 1'b0;
         end else begin
            t = m_acc[g] + s[g];
            if (t > MAXV) begin t = MAXV; m_sat[g] = 1'b1; end
            if (t < MINV) begin t = MINV; m_sat[g] = 1'b1; end
            m_acc[g] = t;
         end
      end
      if (last) begin
         for (int g = 0; g < NG; g++) begin
            t = m_acc[g];
            e.out[g*QW +: QW] = t[31:0];
            m_acc[g] = 0;
         end
         e.sat = m_sat;
         e.cyc = cyc + 3;
         e.tag = tag;
         sb_q.push_back(e);
         m_sat = '0;
      end
   endtask

   task automatic wait_drain(output bit ok);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      ok = (sb_q.size() == 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mac_valid_i = 1'b0; data_mac_i = '0; weight_mac_i = '0; num_groups_i = '0;
      num_macs_i = '0; acc_first_i = 1'b0; acc_last_i = 1'b0;
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
      input_offset_i = '0;
`endif
      for (int g = 0; g < NG; g++) m_acc[g] = 0;
      m_sat = '0;
      #3 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (mac_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", mac_valid_o); end
      n_cmp++; if (mac_out_o !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", mac_out_o); end
      n_cmp++; if (sat_flag_o !== '0) begin n_fail++; $display("FAIL reset_sat got %b want 0", sat_flag_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
      @(negedge clk);
      rst = 1'b1;
      idle(2);
   endtask

   task automatic test_four_groups();
      bit ok;
      beat({64{8'sh02}}, {64{8'sh03}}, 4, {8{6'd16}}, 1'b1, 1'b1, 0, 1);
      idle(1);
      n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_in_flight got %b want 1", busy_o); end
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL four_groups_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (mac_out_o[95:64] !== 32'd96) begin n_fail++; $display("FAIL four_groups_g2 got %0d want 96", mac_out_o[95:64]); end
      n_cmp++; if (mac_out_o[255:128] !== '0) begin n_fail++; $display("FAIL four_groups_upper got %h want 0", mac_out_o[255:128]); end
   endtask

   task automatic test_full_group();
      bit ok;
      beat({64{8'h80}}, {64{8'h80}}, 1, '0, 1'b1, 1'b1, 0, 2);
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_group_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (mac_out_o[31:0] !== 32'd1048576) begin n_fail++; $display("FAIL full_group_g0 got %0d want 1048576", mac_out_o[31:0]); end
      n_cmp++; if (mac_out_o[63:32] !== 32'd0) begin n_fail++; $display("FAIL full_group_g1 got %0d want 0", mac_out_o[63:32]); end
   endtask

   task automatic test_multi_beat();
      bit ok;
      int p;
      p = n_pulses;
      beat({64{8'sh01}}, {64{8'sh05}}, 1, 48'd9, 1'b1, 1'b0, 0, 3);
      idle(5);
      n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_open_acc got %b want 1", busy_o); end
      n_cmp++; if (n_pulses !== p) begin n_fail++; $display("FAIL early_pulse got %0d want %0d", n_pulses, p); end
      beat({64{8'sh01}}, {64{8'sh05}}, 1, 48'd9, 1'b0, 1'b0, 0, 3);
      beat({64{8'sh01}}, {64{8'sh05}}, 1, 48'd9, 1'b0, 1'b1, 0, 3);
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL multi_beat_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (mac_out_o[31:0] !== 32'd135) begin n_fail++; $display("FAIL multi_beat_g0 got %0d want 135", mac_out_o[31:0]); end
      n_cmp++; if (n_pulses !== p + 1) begin n_fail++; $display("FAIL multi_beat_pulses got %0d want %0d", n_pulses, p + 1); end
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b want 0", busy_o); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int p;
      int ngs [8] = '{1, 2, 4, 8, 15, 3, 5, 7};
      logic [DW*NM-1:0] d, w;
      logic [NG*MB-1:0] nm;
      p = n_pulses;
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = $urandom();
            w[i*32 +: 32] = $urandom();
         end
         nm[31:0]  = $urandom();
         nm[47:32] = 16'($urandom_range(0, 65535));
         beat(d, w, ngs[b], nm, 1'b1, 1'b1, 0, 4);
      end
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (n_pulses !== p + 8) begin n_fail++; $display("FAIL b2b_pulses got %0d want %0d", n_pulses, p + 8); end
   endtask

   task automatic test_random();
      bit ok;
      int ng, off;
      logic f, l;
      logic [DW*NM-1:0] d, w;
      logic [NG*MB-1:0] nm;
      for (int b = 0; b < 40; b++) begin
         for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = $urandom();
            w[i*32 +: 32] = $urandom();
         end
         nm[31:0]  = $urandom();
         nm[47:32] = 16'($urandom_range(0, 65535));
         ng = int'($urandom_range(0, 15));
         f  = (b == 0) || ($urandom_range(0, 3) == 0);
         l  = (b == 39) || ($urandom_range(0, 2) == 0);
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
         off = int'($urandom_range(0, 511)) - 256;
`else
         off = 0;
`endif
         beat(d, w, ng, nm, f, l, off, 5);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL random_timeout pending %0d want 0", sb_q.size()); end
   endtask

   task automatic test_saturation();
      bit ok;
      beat({64{8'h80}}, {64{8'h80}}, 1, '0, 1'b1, 1'b0, 0, 6);
      for (int i = 0; i < 2047; i++)
         beat({64{8'h80}}, {64{8'h80}}, 1, '0, 1'b0, 1'b0, 0, 6);
      beat({64{8'h80}}, {64{8'h80}}, 1, '0, 1'b0, 1'b1, 0, 6);
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL sat_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (mac_out_o[31:0] !== 32'h7fffffff) begin n_fail++; $display("FAIL sat_value got %h want 7fffffff", mac_out_o[31:0]); end
      n_cmp++; if (sat_flag_o !== 8'h01) begin n_fail++; $display("FAIL sat_flag got %b want 00000001", sat_flag_o); end
      beat({64{8'h80}}, {64{8'h80}}, 1, '0, 1'b1, 1'b1, 0, 7);
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL sat_clear_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (sat_flag_o !== 8'h00) begin n_fail++; $display("FAIL sat_clear got %b want 00000000", sat_flag_o); end
   endtask

   task automatic test_num_groups_zero();
      bit ok;
      int p;
      p = n_pulses;
      beat({64{8'sh07}}, {64{8'sh09}}, 0, {8{6'd4}}, 1'b1, 1'b1, 0, 8);
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL ng0_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (n_pulses !== p + 1) begin n_fail++; $display("FAIL ng0_pulse got %0d want %0d", n_pulses, p + 1); end
      n_cmp++; if (mac_out_o !== '0) begin n_fail++; $display("FAIL ng0_out got %h want 0", mac_out_o); end
   endtask

`ifdef GROUPED_MAC_INPUT_OFFSET_EN
   task automatic test_offset();
      bit ok;
      beat({64{8'h80}}, {64{8'sh01}}, 1, 48'd8, 1'b1, 1'b1, 1, 9);
      beat({64{8'h80}}, {64{8'sh01}}, 1, 48'd8, 1'b1, 1'b1, 128, 9);
      idle(1);
      wait_drain(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL offset_timeout pending %0d want 0", sb_q.size()); end
      n_cmp++; if (mac_out_o[31:0] !== 32'd0) begin n_fail++; $display("FAIL offset_g0 got %0d want 0", mac_out_o[31:0]); end
   endtask
`endif

   task automatic test_reset_inflight();
      bit ok;
      int p;
      beat({64{8'sh02}}, {64{8'sh03}}, 4, {8{6'd16}}, 1'b1, 1'b1, 0, 10);
      idle(1);
      wait_drain(ok);
      n_cmp++; if (mac_out_o[31:0] !== 32'd96) begin n_fail++; $display("FAIL pre_reset_g0 got %0d want 96", mac_out_o[31:0]); end
      p = n_pulses;
      @(negedge clk);
      mac_valid_i = 1'b1; acc_first_i = 1'b1; acc_last_i = 1'b1;
      @(negedge clk);
      data_mac_i = {64{8'sh05}};
      @(negedge clk);
      mac_valid_i = 1'b0; acc_first_i = 1'b0; acc_last_i = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++; if (mac_out_o !== '0) begin n_fail++; $display("FAIL inflight_out got %h want 0", mac_out_o); end
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL inflight_busy got %b want 0", busy_o); end
      n_cmp++; if (mac_valid_o !== 1'b0) begin n_fail++; $display("FAIL inflight_valid got %b want 0", mac_valid_o); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      n_cmp++; if (n_pulses !== p) begin n_fail++; $display("FAIL inflight_pulses got %0d want %0d", n_pulses, p); end
      n_cmp++; if (mac_out_o !== '0) begin n_fail++; $display("FAIL post_reset_out got %h want 0", mac_out_o); end
   endtask

   initial begin
      test_reset();
      test_four_groups();
      test_full_group();
      test_multi_beat();
      test_back_to_back();
      test_random();
      test_saturation();
      test_num_groups_zero();
`ifdef GROUPED_MAC_INPUT_OFFSET_EN
      test_offset();
`endif
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached, pending %0d", sb_q.size());
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/grouped_mac_array.md
Name: grouped_mac_array

Overview:
- Consumer end of the convolution-to-MAC interface.
- Accepts the packed int8 data and weight lane vectors, the group count and the per-group MAC counts.
- Computes one signed dot product per group through a fixed-latency pipeline and can accumulate over several beats.
- Returns QUANT_WIDTH results per group toward the requant/SRAM write path.

Parameters:
MAX_MACS, 64, number of int8 lanes per beat
DATA_WIDTH, 8, lane width (signed int8)
QUANT_WIDTH, 32, per-group result width
MAX_GROUPS, 8, maximum groups per beat
MAC_BIT_PER_GROUP, 6, width of each per-group MAC-count field

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
mac_valid_i  in  1  beat valid; single-cycle pulse, no backpressure
data_mac_i  in  DATA_WIDTH*MAX_MACS  packed signed data lanes, lane k at bits [8k+:8]
weight_mac_i  in  DATA_WIDTH*MAX_MACS  packed signed weight lanes
num_groups_i  in  $clog2(MAX_GROUPS+1)  active group count
num_macs_i  in  MAX_GROUPS*MAC_BIT_PER_GROUP  per-group lane count, group g at [6g+:6]
acc_first_i  in  1  beat starts a new accumulation
acc_last_i  in  1  beat ends the accumulation; result emitted
mac_valid_o  out  1  result valid pulse
mac_out_o  out  signed MAX_GROUPS*QUANT_WIDTH  group g result at [32g+:32]
sat_flag_o  out  MAX_GROUPS  group g saturated during this accumulation
busy_o  out  1  any pipeline stage or accumulation in flight

Behaviour:
- Reset (async, rst=0):
  - All pipeline valids, accumulators, mac_out_o, sat_flag_o, mac_valid_o and busy_o go to 0 immediately.
  - A beat or accumulation in progress when reset asserts is discarded, with no output.
- Group decode (stage 0, registered on mac_valid_i):
  - Effective count n_g = num_macs field; a field value 0 with g < num_groups_i means 64 lanes.
  - num_groups_i > MAX_GROUPS is clamped to MAX_GROUPS.
  - Group g owns lanes [base_g, base_g+n_g), with base_0 = 0 and base_g = base_{g-1} + n_{g-1}.
  - Lanes at index >= 64 do not exist; a group crossing lane 63 is truncated.
  - Lanes outside every active group contribute 0.
  - Groups with g >= num_groups_i produce 0.
- Stage 1: 64 signed 8x8 products, 16-bit each, masked by lane ownership.
- Stage 2: per-group sum of owned products.
  - Sign-extended to QUANT_WIDTH; no overflow is possible, since 64 * 16384 fits in 22 bits.
- Stage 3: accumulate.
  - acc_first: acc_g = sum_g. Otherwise: acc_g = sat32(acc_g + sum_g).
  - sat32 clamps to [-2^31, 2^31-1] and sets sat_flag bit g.
  - sat_flag clears on acc_first.
- Output:
  - mac_valid_o pulses exactly 3 cycles after a mac_valid_i carrying acc_last_i.
  - mac_out_o and sat_flag_o update on that cycle and hold until the next result.
- Handshake:
  - Back-to-back beats accepted every cycle; the pipeline is fully pipelined.
  - acc_first and acc_last in the same beat form a single-beat dot product.
  - A beat without acc_first following an acc_last beat accumulates onto a zero-cleared accumulator.
  - acc_first while an accumulation is open discards the old partial sum silently.
  - Inputs are ignored when mac_valid_i=0.
- num_groups_i = 0 with acc_last: mac_valid_o still pulses, all groups 0.
- busy_o = OR of stage valids, or an open accumulation (first seen, last not yet seen).

Optional Feature:
- Macro: GROUPED_MAC_INPUT_OFFSET_EN.
- When defined:
  - Adds port input_offset_i, in, 9-bit signed, sampled with the beat.
  - Each data lane becomes data + input_offset (9-bit signed) before multiplication.
  - Products widen to 17 bits, following the TFLite zero-point convention.
- When undefined: the port is absent and raw int8 data is multiplied.

Test Plan:
- Single-beat, 4 groups x 16 lanes; all data=2, weights=3, acc_first=acc_last=1 -> 3 cycles later mac_valid_o=1, groups 0-3 = 96, groups 4-7 = 0.
- num_groups=1, num_macs field 0 (=64); data=-128, weights=-128 -> group0 = 1048576.
- Three beats (first, middle, last), 1 group of 9 lanes, data=1, weights=5 -> a single mac_valid_o after the last beat, group0 = 135.
- Accumulation of repeated +1048576 sums starting from acc near 2^31 -> group0 = 2147483647 and sat_flag_o[0]=1; the next acc_first clears the flag.
- Reset asserted with two beats in flight -> outputs 0 immediately and no mac_valid_o afterwards.
- With the offset feature enabled: input_offset=128, data=-128, weights=1, 8 lanes -> group0 = 0.
